// File: rtl/switch_conditioner_if.sv
// Signal bundle between the raw DIP switch pins and the conditioned outputs
// consumed by the user logic.
interface switch_conditioner_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_level;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_toggle;
    logic             any_event;

    modport master (
        output sw_in,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  sw_toggle,
        input  any_event
    );

    modport slave (
        input  sw_in,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output sw_toggle,
        output any_event
    );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronizes, debounces and edge-detects asynchronous switch bits; produces
// clean levels, one-cycle rise/fall pulses and per-bit toggle latches.
module switch_conditioner #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    switch_conditioner_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_r;
    logic [WIDTH-1:0]            s2_r;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0]            level_r;
    logic [WIDTH-1:0]            rise_r;
    logic [WIDTH-1:0]            fall_r;
    logic [WIDTH-1:0]            toggle_r;
    logic                        any_event_r;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0]            level_s;
    logic [WIDTH-1:0]            rise_s;
    logic [WIDTH-1:0]            fall_s;
    logic [WIDTH-1:0]            toggle_s;

    // Per-bit debounce decision: counts consecutive mismatches between the
    // synchronized input and the accepted level, accepting on the last one.
    always_comb begin
        cnt_s    = cnt_r;
        level_s  = level_r;
        rise_s   = '0;
        fall_s   = '0;
        toggle_s = toggle_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_r[i] == level_r[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_s[i]    = '0;
                level_s[i]  = s2_r[i];
                rise_s[i]   = s2_r[i];
                fall_s[i]   = ~s2_r[i];
                toggle_s[i] = toggle_r[i] ^ s2_r[i];
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r        <= '0;
            s2_r        <= '0;
            cnt_r       <= '0;
            level_r     <= '0;
            rise_r      <= '0;
            fall_r      <= '0;
            toggle_r    <= '0;
            any_event_r <= 1'b0;
        end else begin
            s1_r        <= bus.sw_in;
            s2_r        <= s1_r;
            cnt_r       <= cnt_s;
            level_r     <= level_s;
            rise_r      <= rise_s;
            fall_r      <= fall_s;
            toggle_r    <= toggle_s;
            // Registered alongside the pulses so it tracks them exactly.
            any_event_r <= |(rise_s | fall_s);
        end
    end

    assign bus.sw_level  = level_r;
    assign bus.sw_rise   = rise_r;
    assign bus.sw_fall   = fall_r;
    assign bus.sw_toggle = toggle_r;
    assign bus.any_event = any_event_r;
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench: stimulus pushes hand-computed expected events into a queue;
// a monitor pops one entry each cycle any_event is raised.
module tb_switch_conditioner;
    localparam int LAT = 6;  // stimulus at a falling edge -> output after 6th rising edge

    typedef struct {
        int         due;
        logic [5:0] level;
        logic [5:0] rise;
        logic [5:0] fall;
        logic [5:0] tog;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t q[$];

    switch_conditioner_if #(.WIDTH(6)) bus ();

    switch_conditioner #(
        .WIDTH(6),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] sw, input logic [5:0] lv, input logic [5:0] ri,
                         input logic [5:0] fa, input logic [5:0] tg);
        exp_t e;
        bus.sw_in = sw;
        e.due = cyc + LAT;
        e.level = lv;
        e.rise = ri;
        e.fall = fa;
        e.tog = tg;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (bus.sw_level !== 6'd0 || bus.sw_rise !== 6'd0 || bus.sw_fall !== 6'd0 ||
            bus.sw_toggle !== 6'd0 || bus.any_event !== 1'b0) begin
            fails++;
            $display("FAIL %s: level=%h rise=%h fall=%h tog=%h any=%b, required all 0",
                     name, bus.sw_level, bus.sw_rise, bus.sw_fall, bus.sw_toggle, bus.any_event);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.any_event === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event @%0d: level=%h rise=%h fall=%h tog=%h, required no event",
                             cyc, bus.sw_level, bus.sw_rise, bus.sw_fall, bus.sw_toggle);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.due || bus.sw_level !== e.level || bus.sw_rise !== e.rise ||
                        bus.sw_fall !== e.fall || bus.sw_toggle !== e.tog) begin
                        fails++;
                        $display("FAIL event @%0d: level=%h rise=%h fall=%h tog=%h, required @%0d level=%h rise=%h fall=%h tog=%h",
                                 cyc, bus.sw_level, bus.sw_rise, bus.sw_fall, bus.sw_toggle,
                                 e.due, e.level, e.rise, e.fall, e.tog);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [5:0] press_tog [3];
        press_tog[0] = 6'h25;
        press_tog[1] = 6'h05;
        press_tog[2] = 6'h25;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.sw_in = 6'h3F;
        fork
            monitor();
        join_none

        // switches held high through reset
        wait_cyc(10);
        check_zero("reset_hold");
        reset = 1'b0;
        begin
            exp_t e;
            e.due = cyc + LAT; e.level = 6'h3F; e.rise = 6'h3F; e.fall = 6'h00; e.tog = 6'h3F;
            q.push_back(e);
        end
        wait_cyc(10);

        // reset while levels are high clears everything
        reset = 1'b1;
        bus.sw_in = 6'h00;
        wait_cyc(1);
        check_zero("reset_midop");
        reset = 1'b0;
        wait_cyc(10);

        // clean press and release of bit 2
        issue(6'h04, 6'h04, 6'h04, 6'h00, 6'h04);
        wait_cyc(10);
        issue(6'h00, 6'h00, 6'h00, 6'h04, 6'h04);
        wait_cyc(10);

        // bit 0 glitch of 3 cycles: rejected
        bus.sw_in = 6'h01;
        wait_cyc(3);
        bus.sw_in = 6'h00;
        wait_cyc(10);

        // bit 0 high for 4 cycles: accepted, then falls
        issue(6'h01, 6'h01, 6'h01, 6'h00, 6'h05);
        wait_cyc(4);
        issue(6'h00, 6'h00, 6'h00, 6'h01, 6'h05);
        wait_cyc(10);

        // three press/release cycles on bit 5
        for (int k = 0; k < 3; k++) begin
            issue(6'h20, 6'h20, 6'h20, 6'h00, press_tog[k]);
            wait_cyc(8);
            issue(6'h00, 6'h00, 6'h00, 6'h20, press_tog[k]);
            wait_cyc(8);
        end
        wait_cyc(4);

        // bit 4 high, then bit 1 rises while bit 4 falls
        issue(6'h10, 6'h10, 6'h10, 6'h00, 6'h35);
        wait_cyc(10);
        issue(6'h02, 6'h02, 6'h02, 6'h10, 6'h37);
        wait_cyc(10);

        // reset during bit 3 debounce; full latency after release
        bus.sw_in = 6'h0A;
        wait_cyc(4);
        reset = 1'b1;
        wait_cyc(1);
        check_zero("reset_debounce");
        reset = 1'b0;
        begin
            exp_t e;
            e.due = cyc + LAT; e.level = 6'h0A; e.rise = 6'h0A; e.fall = 6'h00; e.tog = 6'h0A;
            q.push_back(e);
        end
        wait_cyc(12);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: %0d still pending, required 0 (next due @%0d)",
                     q.size(), q[0].due);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
